// File: rtl/serial_bridge_pkg.sv
// Shared constants and FSM encodings for the serial transmit path.
// The buffer and the serializer use the same DEPTH/AW values.
package serial_bridge_pkg;

    localparam int          DEPTH        = 32;
    localparam int          AW           = 5;
    localparam logic [7:0]  PAD_BYTE     = 8'hFF;
    localparam logic [15:0] IDLE_TIMEOUT = 16'd1000;

    // The pointer is one bit wider than the address so that DEPTH itself can be held.
    typedef logic [AW:0] ptr_t;
    localparam ptr_t PTR_FULL = DEPTH[AW:0];
    localparam ptr_t PTR_LAST = PTR_FULL - 1'b1;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_FILL    = 3'd1;
    localparam state_t ST_PAD     = 3'd2;
    localparam state_t ST_DRAIN   = 3'd3;
    localparam state_t ST_RELEASE = 3'd4;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter with a registered one-hot grant.
// It also records the owner of each completed frame.
module rr_arbiter2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       grant_i,
    input  logic       release_i,
    output logic [1:0] gnt_o,
    output logic       owner_o,
    output logic       last_owner_o
);

    logic [1:0] gnt_q, gnt_d;
    logic       prio_q;
    logic       last_q;
    logic       pick;

    // prio_q names the winner of a tie; it starts at 0 so requester 0 wins first.
    always_comb begin
        pick = req_i[1];
        if (req_i == 2'b11) pick = prio_q;
    end

    always_comb begin
        gnt_d = gnt_q;
        if (grant_i && (|req_i)) gnt_d = pick ? 2'b10 : 2'b01;
        else if (release_i)      gnt_d = 2'b00;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            gnt_q  <= 2'b00;
            prio_q <= 1'b0;
            last_q <= 1'b0;
        end else begin
            gnt_q <= gnt_d;
            if (release_i) begin
                last_q <= gnt_q[1];
                prio_q <= ~gnt_q[1];
            end
        end
    end

    assign gnt_o        = gnt_q;
    assign owner_o      = gnt_q[1];
    assign last_owner_o = last_q;

endmodule

// File: rtl/serial_tx_scheduler.sv
// Arbitrates two byte producers into the 32-byte transmit buffer, pads short
// messages, and hands complete frames to the UART serializer.
module serial_tx_scheduler
    import serial_bridge_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [1:0]    req_i,
    output logic [1:0]    gnt_o,
    input  logic [1:0]    wr_en_i,
    input  logic [7:0]    wr_data0_i,
    input  logic [7:0]    wr_data1_i,
    input  logic [1:0]    done_i,
    output logic          buf_we_o,
    output logic [AW-1:0] buf_waddr_o,
    output logic [7:0]    buf_wdata_o,
    output logic          tx_ready_o,
    input  logic          tx_clear_i,
    input  logic          tx_read_i,
    output logic          busy_o,
    output logic          ovf_o,
    output logic          last_owner_o
);

    state_t          state_q, state_d;
    ptr_t            ptr_q, ptr_d;
    ptr_t            rd_cnt_q, rd_cnt_d;
    logic [15:0]     tmo_q, tmo_d;
    logic            we_q, we_d;
    logic [AW-1:0]   waddr_q, waddr_d;
    logic [7:0]      wdata_q, wdata_d;
    logic            ready_q, ready_d;
    logic            ovf_q, ovf_d;

    logic [1:0] gnt;
    logic       owner;
    logic       arb_grant, arb_release;

    rr_arbiter2 u_arb (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_i        (req_i),
        .grant_i      (arb_grant),
        .release_i    (arb_release),
        .gnt_o        (gnt),
        .owner_o      (owner),
        .last_owner_o (last_owner_o)
    );

    // Only the granted requester's strobes are seen; the other side is masked out.
    logic       own_wr, own_done, own_req, accept;
    logic [7:0] own_data;
    assign own_wr   = |(wr_en_i & gnt);
    assign own_done = |(done_i & gnt);
    assign own_req  = |(req_i & gnt);
    assign own_data = owner ? wr_data1_i : wr_data0_i;
    assign accept   = (state_q == ST_FILL) && own_wr && (ptr_q != PTR_FULL);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        rd_cnt_d    = rd_cnt_q;
        tmo_d       = tmo_q;
        we_d        = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        ready_d     = 1'b0;
        ovf_d       = 1'b0;
        arb_grant   = 1'b0;
        arb_release = 1'b0;
        case (state_q)
            ST_IDLE: begin
                arb_grant = 1'b1;
                if (|req_i) begin
                    ptr_d    = '0;
                    tmo_d    = '0;
                    rd_cnt_d = '0;
                    state_d  = ST_FILL;
                end
            end
            ST_FILL: begin
                ovf_d = own_wr && (ptr_q == PTR_FULL);
                if (accept) begin
                    we_d    = 1'b1;
                    waddr_d = ptr_q[AW-1:0];
                    wdata_d = own_data;
                    ptr_d   = ptr_q + 1'b1;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
                // A byte strobed with DONE is written by the same edge that closes the message.
                if (own_done || !own_req || (accept && ptr_q == PTR_LAST) ||
                    (!accept && tmo_q == IDLE_TIMEOUT - 16'd1))
                    state_d = (ptr_d < PTR_FULL) ? ST_PAD : ST_DRAIN;
            end
            ST_PAD: begin
                ovf_d   = own_wr;
                we_d    = 1'b1;
                waddr_d = ptr_q[AW-1:0];
                wdata_d = PAD_BYTE;
                ptr_d   = ptr_q + 1'b1;
                if (ptr_q == PTR_LAST) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                ovf_d = own_wr;
                if (tx_read_i) rd_cnt_d = rd_cnt_q + 1'b1;
                // CLEAR only counts once READY has actually been presented to the serializer.
                if (ready_q && !tx_clear_i) begin
                    arb_release = 1'b1;
                    state_d     = ST_RELEASE;
                end else begin
                    ready_d = 1'b1;
                end
            end
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            rd_cnt_q <= '0;
            tmo_q    <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            ready_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            rd_cnt_q <= rd_cnt_d;
            tmo_q    <= tmo_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            ready_q  <= ready_d;
            ovf_q    <= ovf_d;
        end
    end

    // The drain read count is kept for debug probing; no output depends on it.
    logic unused_rd_cnt;
    assign unused_rd_cnt = ^rd_cnt_q;

    assign gnt_o       = gnt;
    assign buf_we_o    = we_q;
    assign buf_waddr_o = waddr_q;
    assign buf_wdata_o = wdata_q;
    assign tx_ready_o  = ready_q;
    assign ovf_o       = ovf_q;
    assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_serial_tx_scheduler.sv
// Directed bench for serial_tx_scheduler: buffer writes are checked against a
// queue of expected (address, data) pairs pushed as stimulus is driven.
module tb_serial_tx_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req, gnt, wr_en, done;
    logic [7:0] wr_data0, wr_data1, buf_wdata;
    logic [4:0] buf_waddr;
    logic       buf_we, tx_ready, tx_clear, tx_read, busy, ovf, last_owner;

    serial_tx_scheduler dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_i        (req),
        .gnt_o        (gnt),
        .wr_en_i      (wr_en),
        .wr_data0_i   (wr_data0),
        .wr_data1_i   (wr_data1),
        .done_i       (done),
        .buf_we_o     (buf_we),
        .buf_waddr_o  (buf_waddr),
        .buf_wdata_o  (buf_wdata),
        .tx_ready_o   (tx_ready),
        .tx_clear_i   (tx_clear),
        .tx_read_i    (tx_read),
        .busy_o       (busy),
        .ovf_o        (ovf),
        .last_owner_o (last_owner)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  checks = 0;
    int  errors = 0;
    int  we_cnt = 0;
    int  ovf_cnt = 0;
    int  we_base;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int addr, input int data);
        wr_t e;
        e.addr = addr[4:0];
        e.data = data[7:0];
        exp_q.push_back(e);
    endtask

    task automatic wait_ready(input string tag, input int bound);
        int n = 0;
        while (tx_ready !== 1'b1 && n < bound) begin
            cyc();
            n++;
        end
        check(tag, {31'b0, tx_ready}, 1);
    endtask

    // Serializer side: a few reads, then CLEAR low for one cycle.
    task automatic drain(input string tag, input logic exp_last);
        tx_read = 1'b1;
        cyc();
        check({tag, "_ready_hold"}, {31'b0, tx_ready}, 1);
        tx_read  = 1'b0;
        tx_clear = 1'b0;
        cyc();
        check({tag, "_ready_fall"}, {31'b0, tx_ready}, 0);
        check({tag, "_gnt_release"}, {30'b0, gnt}, 0);
        check({tag, "_busy_release"}, {31'b0, busy}, 1);
        check({tag, "_last_owner"}, {31'b0, last_owner}, {31'b0, exp_last});
        tx_clear = 1'b1;
        cyc();
        check({tag, "_busy_idle"}, {31'b0, busy}, 0);
    endtask

    // Scoreboard monitor, sampled on the falling edge away from stimulus changes.
    always @(negedge clk) begin
        if (ovf) ovf_cnt++;
        if (buf_we) begin
            we_cnt++;
            if (exp_q.size() == 0) begin
                check("spurious_we", {31'b0, buf_we}, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("we_addr", {27'b0, buf_waddr}, {27'b0, mon_e.addr});
                check("we_data", {24'b0, buf_wdata}, {24'b0, mon_e.data});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req = 2'b00; wr_en = 2'b00; done = 2'b00;
        wr_data0 = 8'h00; wr_data1 = 8'h00; tx_clear = 1'b1; tx_read = 1'b0;
        cyc();
        cyc();
        check("rst_gnt", {30'b0, gnt}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_ready", {31'b0, tx_ready}, 0);
        check("rst_we", {31'b0, buf_we}, 0);
        check("rst_waddr", {27'b0, buf_waddr}, 0);
        check("rst_wdata", {24'b0, buf_wdata}, 0);
        check("rst_last", {31'b0, last_owner}, 0);

        // Frame 1: both request, requester 0 wins and fills all 32 bytes
        // while requester 1 toggles its strobe without effect.
        rst = 1'b0;
        req = 2'b11;
        cyc();
        check("f1_gnt", {30'b0, gnt}, 2'b01);
        check("f1_busy", {31'b0, busy}, 1);
        we_base = we_cnt;
        for (int i = 0; i < 32; i++) begin
            wr_en    = {i[0], 1'b1};
            wr_data0 = i[7:0];
            wr_data1 = 8'hEE;
            push(i, i);
            cyc();
        end
        wr_en = 2'b00;
        check("f1_ready_not_early", {31'b0, tx_ready}, 0);
        cyc();
        check("f1_ready_rise", {31'b0, tx_ready}, 1);
        check("f1_we_count", we_cnt - we_base, 32);
        drain("f1", 1'b0);

        // Frame 2: both still requesting, requester 1 wins; 3 bytes then padding.
        cyc();
        check("f2_gnt", {30'b0, gnt}, 2'b10);
        we_base = we_cnt;
        for (int i = 0; i < 3; i++) begin
            wr_en    = 2'b10;
            wr_data1 = 8'hA0 + i[7:0];
            done     = (i == 2) ? 2'b10 : 2'b00;
            push(i, 8'hA0 + i);
            cyc();
        end
        for (int i = 3; i < 32; i++) push(i, 8'hFF);
        wr_en = 2'b00;
        done  = 2'b00;
        wait_ready("f2_ready", 40);
        check("f2_queue_empty", exp_q.size(), 0);
        check("f2_we_count", we_cnt - we_base, 32);
        drain("f2", 1'b1);

        // Frame 3: round-robin returns to requester 0; it stalls after 5 bytes.
        cyc();
        check("f3_gnt", {30'b0, gnt}, 2'b01);
        we_base = we_cnt;
        for (int i = 0; i < 5; i++) begin
            wr_en    = 2'b01;
            wr_data0 = 8'h50 + i[7:0];
            push(i, 8'h50 + i);
            cyc();
        end
        wr_en = 2'b00;
        for (int i = 5; i < 32; i++) push(i, 8'hFF);
        repeat (990) cyc();
        check("f3_no_early_close", we_cnt - we_base, 5);
        check("f3_still_granted", {30'b0, gnt}, 2'b01);
        req = 2'b01;
        wait_ready("f3_timeout_ready", 80);
        check("f3_we_count", we_cnt - we_base, 32);
        drain("f3", 1'b0);

        // Frame 4: a 33rd byte after a full frame pulses OVF and writes nothing.
        cyc();
        check("f4_gnt", {30'b0, gnt}, 2'b01);
        we_base = we_cnt;
        for (int i = 0; i < 32; i++) begin
            wr_en    = 2'b01;
            wr_data0 = 8'h60 + i[7:0];
            push(i, 8'h60 + i);
            cyc();
        end
        wr_data0 = 8'h99;
        cyc();
        check("f4_ovf_pulse", {31'b0, ovf}, 1);
        wr_en = 2'b00;
        cyc();
        check("f4_ovf_single", {31'b0, ovf}, 0);
        check("f4_we_count", we_cnt - we_base, 32);
        check("f4_ready", {31'b0, tx_ready}, 1);

        // Reset while draining: outputs clear at once, next request starts at address 0.
        rst = 1'b1;
        #1;
        check("rst_drain_ready", {31'b0, tx_ready}, 0);
        check("rst_drain_gnt", {30'b0, gnt}, 0);
        check("rst_drain_busy", {31'b0, busy}, 0);
        cyc();
        rst = 1'b0;
        req = 2'b10;
        cyc();
        check("f5_gnt", {30'b0, gnt}, 2'b10);
        we_base = we_cnt;
        for (int i = 0; i < 2; i++) begin
            wr_en    = 2'b10;
            wr_data1 = 8'h70 + i[7:0];
            done     = (i == 1) ? 2'b10 : 2'b00;
            push(i, 8'h70 + i);
            cyc();
        end
        for (int i = 2; i < 32; i++) push(i, 8'hFF);
        wr_en = 2'b00;
        done  = 2'b00;
        req   = 2'b00;
        wait_ready("f5_ready", 40);
        check("f5_we_count", we_cnt - we_base, 32);
        drain("f5", 1'b1);

        check("final_queue_empty", exp_q.size(), 0);
        check("ovf_total", ovf_cnt, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
